// File: rtl/mem_wb_stage_if.sv
// MEM-stage request and WB-stage result bundle between the pipeline control and mem_wb_stage.
interface mem_wb_stage_if #(
   parameter int REG_AW = 5
);
   logic              Stall;
   logic              Flush;
   logic [31:0]       AluResult;
   logic [31:0]       ReadData2;
   logic              MemRead;
   logic              MemWrite;
   logic [1:0]        MemSize;
   logic              MemUnsigned;
   logic              MemtoReg;
   logic              RegWrite;
   logic [REG_AW-1:0] WriteReg;
   logic [31:0]       WriteDataReg;
   logic              WbRegWrite;
   logic [REG_AW-1:0] WbWriteReg;
   logic              MemErr;

   modport master (
      output Stall, Flush, AluResult, ReadData2, MemRead, MemWrite, MemSize,
             MemUnsigned, MemtoReg, RegWrite, WriteReg,
      input  WriteDataReg, WbRegWrite, WbWriteReg, MemErr
   );

   modport slave (
      input  Stall, Flush, AluResult, ReadData2, MemRead, MemWrite, MemSize,
             MemUnsigned, MemtoReg, RegWrite, WriteReg,
      output WriteDataReg, WbRegWrite, WbWriteReg, MemErr
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM+WB stage: data memory with registered read, byte/half/word stores and
// sign/zero-extended loads, MEM/WB pipeline register and writeback mux.
module mem_wb_stage #(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 8,
   parameter int REG_AW    = 5
) (
   input logic           Clk,
   input logic           Rst_n,
   mem_wb_stage_if.slave bus
);
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic              access;
   logic              misaligned;
   logic              illegal;
   logic              store_en;
   logic [3:0]        lane_we;
   logic [31:0]       wdata;
   logic              unused_hi;

   logic [31:0]       mem_q [MEM_WORDS];
   logic [31:0]       rdata_q;

   logic [31:0]       alu_q,       alu_d;
   logic              memtoreg_q,  memtoreg_d;
   logic              regwrite_q,  regwrite_d;
   logic [REG_AW-1:0] writereg_q,  writereg_d;
   logic              err_q,       err_d;
   logic [1:0]        lane_q,      lane_d;
   logic [1:0]        size_q,      size_d;
   logic              unsigned_q,  unsigned_d;

   logic [31:0]       shifted;
   logic [31:0]       load_ext;

   // Address bits above the memory depth are ignored, so accesses wrap.
   assign idx       = bus.AluResult[ADDR_W+1:2];
   assign lane      = bus.AluResult[1:0];
   assign unused_hi = ^bus.AluResult[31:ADDR_W+2];

   always_comb begin
      access = bus.MemRead | bus.MemWrite;
      case (bus.MemSize)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = |lane;
         default: misaligned = 1'b1;
      endcase
      illegal  = access & (misaligned | (bus.MemRead & bus.MemWrite));
      store_en = bus.MemWrite & ~bus.Stall & ~bus.Flush & Rst_n & ~illegal;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = (bus.MemSize == 2'b10)
                         | ((bus.MemSize == 2'b01) && (lane[1] == (gi >= 2)))
                         | ((bus.MemSize == 2'b00) && (lane == 2'(gi)));
      assign wdata[8*gi +: 8] = (bus.MemSize == 2'b10) ? bus.ReadData2[8*gi +: 8] :
                                (bus.MemSize == 2'b01) ? bus.ReadData2[8*(gi%2) +: 8] :
                                                         bus.ReadData2[7:0];
   end

   // Memory array has no reset; the read register holds with the pipeline under stall.
   always_ff @(posedge Clk) begin
      if (store_en) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) mem_q[idx][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
      if (bus.Flush || !bus.Stall) rdata_q <= mem_q[idx];
   end

   always_comb begin
      alu_d      = alu_q;
      memtoreg_d = memtoreg_q;
      regwrite_d = regwrite_q;
      writereg_d = writereg_q;
      err_d      = err_q;
      lane_d     = lane_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      if (bus.Flush) begin
         alu_d      = '0;
         memtoreg_d = 1'b0;
         regwrite_d = 1'b0;
         writereg_d = '0;
         err_d      = 1'b0;
         lane_d     = '0;
         size_d     = '0;
         unsigned_d = 1'b0;
      end else if (!bus.Stall) begin
         alu_d      = bus.AluResult;
         memtoreg_d = bus.MemtoReg;
         regwrite_d = bus.RegWrite;
         writereg_d = bus.WriteReg;
         err_d      = illegal;
         lane_d     = lane;
         size_d     = bus.MemSize;
         unsigned_d = bus.MemUnsigned;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         alu_q      <= '0;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         writereg_q <= '0;
         err_q      <= 1'b0;
         lane_q     <= '0;
         size_q     <= '0;
         unsigned_q <= 1'b0;
      end else begin
         alu_q      <= alu_d;
         memtoreg_q <= memtoreg_d;
         regwrite_q <= regwrite_d;
         writereg_q <= writereg_d;
         err_q      <= err_d;
         lane_q     <= lane_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
      end
   end

   // Lane extraction: shift the addressed lane down, then extend by size.
   always_comb begin
      shifted = rdata_q >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   load_ext = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
         default: load_ext = rdata_q;
      endcase
   end

   always_comb begin
      bus.WriteDataReg = err_q ? 32'h0 : (memtoreg_q ? load_ext : alu_q);
      bus.WbRegWrite   = regwrite_q & ~err_q;
      bus.WbWriteReg   = writereg_q;
      bus.MemErr       = err_q;
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic against a
// byte-addressed memory model.
module tb_mem_wb_stage;
   localparam int MEM_WORDS = 256;
   localparam int ADDR_W    = 8;
   localparam int REG_AW    = 5;
   localparam int BYTES     = MEM_WORDS * 4;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b1;
   always #5 Clk = ~Clk;

   mem_wb_stage_if #(.REG_AW(REG_AW)) bus();

   mem_wb_stage #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   byte unsigned      mem_b [BYTES];
   logic [31:0]       exp_data;
   logic              exp_we;
   logic              exp_err;
   logic [REG_AW-1:0] exp_wreg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      exp_data = '0;
      exp_we   = 1'b0;
      exp_err  = 1'b0;
      exp_wreg = '0;
   endtask

   // Reference: what the WB outputs must show after this edge, from the inputs at the edge.
   task automatic model_edge();
      int          nb;
      int          a;
      logic        bad;
      logic [31:0] v;
      if (!Rst_n || bus.Flush) begin
         clear_exp();
         return;
      end
      if (bus.Stall) return;
      nb  = 1 << bus.MemSize;
      a   = int'(bus.AluResult % BYTES);
      bad = (bus.MemRead || bus.MemWrite) &&
            (bus.MemSize == 2'b11 || (bus.MemRead && bus.MemWrite) || (a % nb) != 0);
      exp_wreg = bus.WriteReg;
      if (bad) begin
         exp_data = '0;
         exp_we   = 1'b0;
         exp_err  = 1'b1;
         return;
      end
      exp_err = 1'b0;
      exp_we  = bus.RegWrite;
      if (bus.MemtoReg) begin
         v = '0;
         for (int k = 0; k < nb; k++) v = v | (32'(mem_b[a + k]) << (8 * k));
         if (!bus.MemUnsigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         exp_data = v;
      end else begin
         exp_data = bus.AluResult;
      end
      if (bus.MemWrite) begin
         for (int k = 0; k < nb; k++) mem_b[a + k] = 8'(bus.ReadData2 >> (8 * k));
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_data"}, bus.WriteDataReg, exp_data);
      chk({tag, "_we"},   32'(bus.WbRegWrite), 32'(exp_we));
      chk({tag, "_err"},  32'(bus.MemErr), 32'(exp_err));
      if (exp_we) chk({tag, "_wreg"}, 32'(bus.WbWriteReg), 32'(exp_wreg));
   endtask

   task automatic op(input string tag, input logic st, input logic fl, input logic rd,
                     input logic wr, input logic [1:0] sz, input logic un, input logic rw,
                     input logic [REG_AW-1:0] wreg, input logic [31:0] alu, input logic [31:0] wd);
      bus.Stall       = st;
      bus.Flush       = fl;
      bus.MemRead     = rd;
      bus.MemWrite    = wr;
      bus.MemSize     = sz;
      bus.MemUnsigned = un;
      bus.MemtoReg    = rd;
      bus.RegWrite    = rw;
      bus.WriteReg    = wreg;
      bus.AluResult   = alu;
      bus.ReadData2   = wd;
      @(posedge Clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      op(tag, 1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0, 1'b0, '0, a, d);
   endtask

   task automatic load(input string tag, input logic [1:0] sz, input logic un, input logic [31:0] a,
                       input logic [REG_AW-1:0] r);
      op(tag, 1'b0, 1'b0, 1'b1, 1'b0, sz, un, 1'b1, r, a, 32'h0);
   endtask

   initial begin
      logic              st, fl, rd, wr, un, rw;
      logic [1:0]        sz;
      logic [31:0]       alu;
      int                kind;

      bus.Stall = 0; bus.Flush = 0; bus.MemRead = 0; bus.MemWrite = 0; bus.MemSize = 0;
      bus.MemUnsigned = 0; bus.MemtoReg = 0; bus.RegWrite = 0; bus.WriteReg = '0;
      bus.AluResult = '0; bus.ReadData2 = '0;
      clear_exp();

      #1 Rst_n = 1'b0;
      #2;
      chk("rst_data", bus.WriteDataReg, 32'h0);
      chk("rst_we",   32'(bus.WbRegWrite), 32'h0);
      chk("rst_wreg", 32'(bus.WbWriteReg), 32'h0);
      chk("rst_err",  32'(bus.MemErr), 32'h0);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;

      for (int w = 0; w < MEM_WORDS; w++) store("fill", 2'b10, 32'(w * 4), $urandom);

      store("t1_sw", 2'b10, 32'h10, 32'hDEAD_BEEF);
      load("t1_lw", 2'b10, 1'b0, 32'h10, 5'd8);
      chk("t1_lw_const", bus.WriteDataReg, 32'hDEAD_BEEF);
      chk("t1_wreg_const", 32'(bus.WbWriteReg), 32'd8);

      store("t2_sb", 2'b00, 32'h13, 32'h0000_0080);
      load("t2_lb", 2'b00, 1'b0, 32'h13, 5'd9);
      chk("t2_lb_const", bus.WriteDataReg, 32'hFFFF_FF80);
      load("t2_lbu", 2'b00, 1'b1, 32'h13, 5'd9);
      chk("t2_lbu_const", bus.WriteDataReg, 32'h0000_0080);
      load("t2_lw", 2'b10, 1'b0, 32'h10, 5'd9);
      chk("t2_lw_const", bus.WriteDataReg, 32'h80AD_BEEF);

      store("t3_sh_mis", 2'b01, 32'h11, 32'h0000_1234);
      chk("t3_sh_err_const", 32'(bus.MemErr), 32'h1);
      load("t3_lw_mis", 2'b10, 1'b0, 32'h12, 5'd10);
      load("t3_lw_ok", 2'b10, 1'b0, 32'h10, 5'd10);
      chk("t3_mem_const", bus.WriteDataReg, 32'h80AD_BEEF);
      load("t3_lh_ok", 2'b01, 1'b0, 32'h12, 5'd10);
      op("t3_rsv", 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 5'd11, 32'h10, 32'h0);

      op("t4_r", 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3, 32'd32, 32'h0);
      chk("t4_r_const", bus.WriteDataReg, 32'd32);
      for (int i = 0; i < 3; i++)
         op("t4_stall", 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'h10, 32'h1234_5678);
      chk("t4_hold_const", bus.WriteDataReg, 32'd32);
      load("t4_lw", 2'b10, 1'b0, 32'h10, 5'd4);

      op("t5_flush", 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'h20, 32'hCAFE_F00D);
      load("t5_lw", 2'b10, 1'b0, 32'h20, 5'd5);
      op("t5_r", 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd6, 32'd77, 32'h0);
      op("t5_fl_st", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd6, 32'd99, 32'h0);
      chk("t5_bubble_const", 32'(bus.WbRegWrite), 32'h0);

      store("t6_sw_wrap", 2'b10, 32'(BYTES + 4), 32'hA5A5_0F0F);
      load("t6_lw", 2'b10, 1'b0, 32'h4, 5'd7);
      chk("t6_wrap_const", bus.WriteDataReg, 32'hA5A5_0F0F);

      #2 Rst_n = 1'b0;
      #1;
      clear_exp();
      chk("t6_arst_data", bus.WriteDataReg, 32'h0);
      chk("t6_arst_we",   32'(bus.WbRegWrite), 32'h0);
      chk("t6_arst_wreg", 32'(bus.WbWriteReg), 32'h0);
      store("t6_sw_inrst", 2'b10, 32'h30, 32'h1111_2222);
      Rst_n = 1'b1;
      load("t6_lw_after", 2'b10, 1'b0, 32'h30, 5'd12);

      for (int i = 0; i < 400; i++) begin
         st   = ($urandom_range(0, 99) < 12);
         fl   = ($urandom_range(0, 99) < 8);
         kind = $urandom_range(0, 9);
         rd   = (kind < 4) || (kind == 9);
         wr   = (kind >= 4 && kind < 7) || (kind == 9);
         sz   = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         alu  = $urandom;
         if (sz != 2'b11 && $urandom_range(0, 3) != 0) alu = alu & ~((32'h1 << sz) - 32'h1);
         un   = 1'($urandom_range(0, 1));
         rw   = rd ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
         op("rand", st, fl, rd, wr, sz, un, rw, REG_AW'($urandom), alu, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
